radix2_butterfly_cfg: RTL and testbench

- Parametrised radix-2 butterfly for the FFT engine.
- Per operation it runs either decimation-in-frequency (DIF) or decimation-in-time (DIT) arithmetic, with optional divide-by-2 scaling, output saturation, and a pipeline-wide clock-enable stall.
- It also produces sticky overflow and growth flags, which the stage controller uses for block-floating-point exponent tracking.
- Sits between the twiddle ROM/bank-read logic and the bank-write logic; sideband ctrl/address travel with the data.

---
 rtl/radix2_butterfly_cfg.sv | 145 ++++++++++++++
 tb/tb_radix2_butterfly_cfg.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/radix2_butterfly_cfg.sv
// radix2_butterfly_cfg: pipelined DIF/DIT radix-2 butterfly with scaling, saturation and sticky BFP flags
module radix2_butterfly_cfg #(
  parameter int DW = 16,
  parameter int TW_DW = 16,
  parameter int ADDR_W = 9,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              iact,
  input  logic [CTRL_W-1:0] ictrl,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              imode,
  input  logic              iscale,
  input  logic [DW-1:0]     A_real,
  input  logic [DW-1:0]     A_imag,
  input  logic [DW-1:0]     B_real,
  input  logic [DW-1:0]     B_imag,
  input  logic [TW_DW-1:0]  twiddle_real,
  input  logic [TW_DW-1:0]  twiddle_imag,
  input  logic              clr_status,
  output logic              oact,
  output logic [CTRL_W-1:0] octrl,
  output logic [ADDR_W-1:0] oaddr,
  output logic [DW-1:0]     out_A_real,
  output logic [DW-1:0]     out_A_imag,
  output logic [DW-1:0]     out_B_real,
  output logic [DW-1:0]     out_B_imag,
  output logic              ovf,
  output logic              grow
);
  localparam int SW = DW + 1;
  localparam int PW = DW + 1 + TW_DW;
  localparam int CW = PW + 1;
  localparam int XW = DW + 4;
  localparam logic signed [CW-1:0] HALF = CW'(1) <<< (TW_DW - 2);
  localparam logic signed [XW-1:0] MAXV = XW'(2 ** (DW - 1) - 1);
  localparam logic signed [XW-1:0] MINV = ~MAXV;
  localparam logic signed [XW-1:0] GROWV = XW'(2 ** (DW - 2));
  localparam logic signed [XW-1:0] NGROWV = -GROWV;
  // returns {clamped, grown, value}
  function automatic logic [DW+1:0] scale_sat(input logic signed [XW-1:0] x, input logic sc);
    logic signed [XW-1:0] y, q;
    y = sc ? (x + XW'(1)) >>> 1 : x;
    q = y > MAXV ? MAXV : (y < MINV ? MINV : y);
    return {y != q, q >= GROWV || q < NGROWV, q[DW-1:0]};
  endfunction
  logic signed [SW-1:0] a_re, a_im, b_re, b_im;
  assign a_re = SW'($signed(A_real));
  assign a_im = SW'($signed(A_imag));
  assign b_re = SW'($signed(B_real));
  assign b_im = SW'($signed(B_imag));
  logic                     v1, v2, v3, v4;
  logic                     md1, md2, sc1, sc2, sc3;
  logic [CTRL_W-1:0]        ct1, ct2, ct3, ct4;
  logic [ADDR_W-1:0]        ad1, ad2, ad3, ad4;
  logic signed [SW-1:0]     m1_re, m1_im, p1_re, p1_im, p2_re, p2_im;
  logic signed [TW_DW-1:0]  w1_re, w1_im;
  logic signed [PW-1:0]     prr, pii, pri, pir;
  logic signed [CW-1:0]     c_re, c_im;
  logic signed [XW-1:0]     bw_re, bw_im, pe_re, pe_im;
  logic [3:0][XW-1:0]       x3;
  logic [3:0][DW-1:0]       q_c, q4;
  logic [3:0]               sat_c, grow_c;
  logic                     sat4, grow4;
  assign c_re  = CW'(prr) - CW'(pii);
  assign c_im  = CW'(pri) + CW'(pir);
  assign bw_re = XW'((c_re + HALF) >>> (TW_DW - 1));
  assign bw_im = XW'((c_im + HALF) >>> (TW_DW - 1));
  assign pe_re = XW'(p2_re);
  assign pe_im = XW'(p2_im);
  for (genvar i = 0; i < 4; i++) begin : g_sat
    assign {sat_c[i], grow_c[i], q_c[i]} = scale_sat($signed(x3[i]), sc3);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {v1, v2, v3, v4, oact} <= '0;
      {md1, md2, sc1, sc2, sc3, sat4, grow4} <= '0;
      {ct1, ct2, ct3, ct4, octrl} <= '0;
      {ad1, ad2, ad3, ad4, oaddr} <= '0;
      {m1_re, m1_im, p1_re, p1_im, p2_re, p2_im, w1_re, w1_im} <= '0;
      {prr, pii, pri, pir} <= '0;
      x3 <= '0;
      q4 <= '0;
      {out_A_real, out_A_imag, out_B_real, out_B_imag} <= '0;
    end else if (ce) begin
      v1    <= iact;
      md1   <= imode;
      sc1   <= iscale;
      ct1   <= ictrl;
      ad1   <= iaddr;
      m1_re <= imode ? b_re : a_re - b_re;
      m1_im <= imode ? b_im : a_im - b_im;
      p1_re <= imode ? a_re : a_re + b_re;
      p1_im <= imode ? a_im : a_im + b_im;
      w1_re <= $signed(twiddle_real);
      w1_im <= $signed(twiddle_imag);
      v2    <= v1;
      md2   <= md1;
      sc2   <= sc1;
      ct2   <= ct1;
      ad2   <= ad1;
      p2_re <= p1_re;
      p2_im <= p1_im;
      prr   <= PW'(m1_re) * PW'(w1_re);
      pii   <= PW'(m1_im) * PW'(w1_im);
      pri   <= PW'(m1_re) * PW'(w1_im);
      pir   <= PW'(m1_im) * PW'(w1_re);
      v3    <= v2;
      sc3   <= sc2;
      ct3   <= ct2;
      ad3   <= ad2;
      x3[0] <= md2 ? pe_re + bw_re : pe_re;
      x3[1] <= md2 ? pe_im + bw_im : pe_im;
      x3[2] <= md2 ? pe_re - bw_re : bw_re;
      x3[3] <= md2 ? pe_im - bw_im : bw_im;
      v4    <= v3;
      ct4   <= ct3;
      ad4   <= ad3;
      q4    <= q_c;
      sat4  <= |sat_c;
      grow4 <= |grow_c;
      oact  <= v4;
      if (v4) begin
        octrl      <= ct4;
        oaddr      <= ad4;
        out_A_real <= q4[0];
        out_A_imag <= q4[1];
        out_B_real <= q4[2];
        out_B_imag <= q4[3];
      end
    end
  end
  // clear acts even while stalled; a coincident set wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf  <= 1'b0;
      grow <= 1'b0;
    end else begin
      ovf  <= (ovf & ~clr_status) | (ce & v4 & sat4);
      grow <= (grow & ~clr_status) | (ce & v4 & grow4);
    end
  end
endmodule

// File: tb/tb_radix2_butterfly_cfg.sv
// tb_radix2_butterfly_cfg: directed self-checking bench for the radix-2 butterfly
module tb_radix2_butterfly_cfg;
  localparam int DW = 16, TW = 16, AW = 9, CTW = 2;
  logic clk = 0, reset = 1, ce = 1, iact = 0, imode = 0, iscale = 0, clr_status = 0;
  logic [CTW-1:0] ictrl = '0;
  logic [AW-1:0] iaddr = '0;
  logic [DW-1:0] A_real = '0, A_imag = '0, B_real = '0, B_imag = '0;
  logic [TW-1:0] twiddle_real = '0, twiddle_imag = '0;
  logic oact, ovf, grow;
  logic [CTW-1:0] octrl;
  logic [AW-1:0] oaddr;
  logic signed [DW-1:0] out_A_real, out_A_imag, out_B_real, out_B_imag;
  int checks = 0, errors = 0;
  radix2_butterfly_cfg #(.DW(DW), .TW_DW(TW), .ADDR_W(AW), .CTRL_W(CTW)) dut (
    .clk(clk), .reset(reset), .ce(ce), .iact(iact), .ictrl(ictrl), .iaddr(iaddr),
    .imode(imode), .iscale(iscale), .A_real(A_real), .A_imag(A_imag),
    .B_real(B_real), .B_imag(B_imag), .twiddle_real(twiddle_real),
    .twiddle_imag(twiddle_imag), .clr_status(clr_status), .oact(oact),
    .octrl(octrl), .oaddr(oaddr), .out_A_real(out_A_real), .out_A_imag(out_A_imag),
    .out_B_real(out_B_real), .out_B_imag(out_B_imag), .ovf(ovf), .grow(grow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit md, input bit sc, input int ar, input int ai, input int br,
                       input int bi, input int wr, input int wi, input int ad, input int ct);
    iact = 1; imode = md; iscale = sc;
    A_real = 16'(ar); A_imag = 16'(ai); B_real = 16'(br); B_imag = 16'(bi);
    twiddle_real = 16'(wr); twiddle_imag = 16'(wi);
    iaddr = 9'(ad); ictrl = 2'(ct);
  endtask
  task automatic run_op(input bit md, input bit sc, input int ar, input int ai, input int br,
                        input int bi, input int wr, input int wi, input int ad, input int ct);
    drive(md, sc, ar, ai, br, bi, wr, wi, ad, ct);
    step();
    iact = 0;
    repeat (3) step();
    check("lat_early", oact, 0);
    step();
    check("lat_oact", oact, 1);
  endtask
  task automatic check_out(input string tag, input int ar, input int ai, input int br, input int bi);
    check({tag, "_ar"}, out_A_real, ar);
    check({tag, "_ai"}, out_A_imag, ai);
    check({tag, "_br"}, out_B_real, br);
    check({tag, "_bi"}, out_B_imag, bi);
  endtask
  initial begin
    int nxt, got, seen;
    int ar, ai, br, bi, ea_r, ea_i, eb_r, eb_i;
    bit en;
    #1 reset = 0;
    #3;
    check("rst_oact", oact, 0);
    check("rst_ovf", ovf, 0);
    check("rst_grow", grow, 0);
    check("rst_data", out_A_real, 0);
    #10 reset = 1;
    step();
    // DIF, W ~ 1
    run_op(0, 0, 1000, 0, 200, 0, 32767, 0, 1, 1);
    check_out("dif", 1200, 0, 800, 0);
    check("dif_addr", oaddr, 1);
    check("dif_ctrl", octrl, 1);
    check("dif_ovf", ovf, 0);
    check("dif_grow", grow, 0);
    // DIT, W = -j
    run_op(1, 0, 10, 10, 100, 50, 0, -32768, 2, 2);
    check_out("dit", 60, -90, -40, 110);
    repeat (2) step();
    check("hold_oact", oact, 0);
    check("hold_data", out_A_imag, -90);
    // saturation then scaled retry
    run_op(0, 0, 32000, 0, 32000, 0, 32767, 0, 3, 3);
    check_out("sat", 32767, 0, 0, 0);
    check("sat_ovf", ovf, 1);
    check("sat_grow", grow, 1);
    clr_status = 1;
    step();
    clr_status = 0;
    check("clr_ovf", ovf, 0);
    check("clr_grow", grow, 0);
    run_op(0, 1, 32000, 0, 32000, 0, 32767, 0, 4, 0);
    check_out("scl", 32000, 0, 0, 0);
    check("scl_ovf", ovf, 0);
    check("scl_grow", grow, 1);
    // clear coincident with a saturating result: set wins
    drive(0, 0, 32000, 0, 32000, 0, 32767, 0, 5, 1);
    step();
    iact = 0;
    repeat (3) step();
    clr_status = 1;
    step();
    clr_status = 0;
    check("coin_oact", oact, 1);
    check("coin_ovf", ovf, 1);
    // clear still acts while stalled; outputs freeze
    ce = 0;
    clr_status = 1;
    step();
    clr_status = 0;
    check("stall_clr_ovf", ovf, 0);
    check("stall_oact", oact, 1);
    ce = 1;
    step();
    // stream 8 ops, alternating mode, 3-cycle stall, W ~ +j
    nxt = 0;
    got = 0;
    for (int s = 0; s < 30; s++) begin
      ce = !(s >= 5 && s <= 7);
      if (nxt < 8) drive(nxt[0], 0, 100 * nxt + 10, 5 * nxt, 3 * nxt, 7 + nxt, 0, 32767, nxt, nxt & 3);
      else iact = 0;
      en = ce;
      step();
      if (en && nxt < 8) nxt++;
      if (en && oact) begin
        if (got < 8) begin
          ar = 100 * got + 10; ai = 5 * got; br = 3 * got; bi = 7 + got;
          ea_r = got[0] ? ar - bi : ar + br;
          ea_i = got[0] ? ai + br : ai + bi;
          eb_r = got[0] ? ar + bi : bi - ai;
          eb_i = got[0] ? ai - br : ar - br;
          check("s_addr", oaddr, got);
          check("s_ctrl", octrl, got & 3);
          check_out("s", ea_r, ea_i, eb_r, eb_i);
        end
        got++;
      end else if (en && got > 0 && got < 8) check("s_gap", oact, 1);
    end
    ce = 1;
    check("s_count", got, 8);
    // reset with 3 ops in flight after flags are set
    run_op(0, 0, 32000, 0, 32000, 0, 32767, 0, 6, 2);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 32000, 0, 32000, 0, 32767, 0, 7 + k, 0);
      step();
    end
    iact = 0;
    #2 reset = 0;
    #1;
    check("ar_oact", oact, 0);
    check("ar_ovf", ovf, 0);
    check("ar_grow", grow, 0);
    check("ar_data", out_A_real, 0);
    step();
    reset = 1;
    seen = 0;
    repeat (8) begin
      step();
      if (oact) seen++;
    end
    check("ar_ghost", seen, 0);
    run_op(1, 0, 10, 10, 100, 50, 0, -32768, 12, 3);
    check_out("ar_new", 60, -90, -40, 110);
    check("ar_addr", oaddr, 12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
